// File: rtl/relay_coil_driver.sv
// relay_coil_driver
//   Drives a relay coil from an active-low energise request. Each activation
//   starts with a full-strength pull-in pulse, then drops to a reduced-duty
//   PWM hold. After any release or fault clear, the coil is held off for a
//   minimum lockout time. A latched fault trips if the coil stays energised
//   too long. Activations are counted, and the count saturates.
//
// Ports
//   clk          system clock
//   reset        asynchronous active-low reset
//   relay_req_n  energise request, active-low (same clock domain)
//   fault_clr    fault clear, honoured only while the request is released
//   coil_drv     coil driver gate (1 = current flows)
//   relay_on     high while in PULLIN or HOLD
//   fault        latched over-time fault
//   act_count    activation counter, saturating at 16'hFFFF
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | coil off, waiting for a request
// PULLIN  | full drive for PULLIN_COUNT cycles
// HOLD    | PWM drive, HOLD_DUTY of every 16 cycles, until release/timeout
// LOCKOUT | coil off for MIN_OFF_COUNT cycles, requests ignored
// FAULT   | coil off, fault latched until cleared with request released

module relay_coil_driver #(
    parameter int unsigned CLK_FREQ   = 50_000_000,
    parameter int unsigned PULLIN_MS  = 50,
    parameter int unsigned HOLD_DUTY  = 6,
    parameter int unsigned MIN_OFF_MS = 500,
    parameter int unsigned MAX_ON_SEC = 60
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        relay_req_n,
    input  logic        fault_clr,
    output logic        coil_drv,
    output logic        relay_on,
    output logic        fault,
    output logic [15:0] act_count
);

    localparam logic [31:0] PULLIN_COUNT  = 32'((CLK_FREQ / 1000) * PULLIN_MS);
    localparam logic [31:0] MIN_OFF_COUNT = 32'((CLK_FREQ / 1000) * MIN_OFF_MS);
    localparam logic [31:0] MAX_ON_COUNT  = 32'(CLK_FREQ * MAX_ON_SEC);
    // One bit wider than pwm_cnt so that a duty of 16 means continuous drive.
    localparam logic [4:0]  DUTY          = 5'(HOLD_DUTY);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PULLIN,
        S_HOLD,
        S_LOCKOUT,
        S_FAULT
    } state_t;

    state_t      state_q;
    logic [31:0] on_timer_q;
    logic [31:0] off_timer_q;
    logic [3:0]  pwm_cnt_q;
    logic        coil_drv_q;
    logic        relay_on_q;
    logic        fault_q;
    logic [15:0] act_count_q;

    logic [3:0]  pwm_cnt_d;

    assign pwm_cnt_d = pwm_cnt_q + 4'd1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            on_timer_q  <= '0;
            off_timer_q <= '0;
            pwm_cnt_q   <= '0;
            coil_drv_q  <= 1'b0;
            relay_on_q  <= 1'b0;
            fault_q     <= 1'b0;
            act_count_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (!relay_req_n) begin
                        state_q    <= S_PULLIN;
                        on_timer_q <= '0;
                        coil_drv_q <= 1'b1;
                        relay_on_q <= 1'b1;
                        if (act_count_q != 16'hFFFF) begin
                            act_count_q <= act_count_q + 16'd1;
                        end
                    end
                end

                S_PULLIN: begin
                    if (relay_req_n) begin
                        state_q     <= S_LOCKOUT;
                        off_timer_q <= '0;
                        coil_drv_q  <= 1'b0;
                        relay_on_q  <= 1'b0;
                    end else begin
                        // on_timer keeps running into HOLD so the over-time
                        // limit covers the total energised time.
                        on_timer_q <= on_timer_q + 32'd1;
                        if (on_timer_q == PULLIN_COUNT - 32'd1) begin
                            state_q    <= S_HOLD;
                            pwm_cnt_q  <= '0;
                            coil_drv_q <= (DUTY != 5'd0);
                        end
                    end
                end

                S_HOLD: begin
                    // A release in the same cycle as the timeout takes
                    // priority, so no fault is raised.
                    if (relay_req_n) begin
                        state_q     <= S_LOCKOUT;
                        off_timer_q <= '0;
                        coil_drv_q  <= 1'b0;
                        relay_on_q  <= 1'b0;
                    end else if (on_timer_q == MAX_ON_COUNT - 32'd1) begin
                        state_q    <= S_FAULT;
                        coil_drv_q <= 1'b0;
                        relay_on_q <= 1'b0;
                        fault_q    <= 1'b1;
                    end else begin
                        on_timer_q <= on_timer_q + 32'd1;
                        pwm_cnt_q  <= pwm_cnt_d;
                        coil_drv_q <= ({1'b0, pwm_cnt_d} < DUTY);
                    end
                end

                S_LOCKOUT: begin
                    if (off_timer_q == MIN_OFF_COUNT - 32'd1) begin
                        state_q <= S_IDLE;
                    end else begin
                        off_timer_q <= off_timer_q + 32'd1;
                    end
                end

                S_FAULT: begin
                    if (fault_clr && relay_req_n) begin
                        state_q     <= S_LOCKOUT;
                        off_timer_q <= '0;
                        fault_q     <= 1'b0;
                    end
                end

                default: begin
                    state_q    <= S_IDLE;
                    coil_drv_q <= 1'b0;
                    relay_on_q <= 1'b0;
                    fault_q    <= 1'b0;
                end
            endcase
        end
    end

    assign coil_drv  = coil_drv_q;
    assign relay_on  = relay_on_q;
    assign fault     = fault_q;
    assign act_count = act_count_q;

endmodule

// File: tb/tb_relay_coil_driver.sv
module tb_relay_coil_driver;

    logic        clk;
    logic        rst_n;
    logic        req_n;
    logic        fault_clr;
    logic        coil_drv;
    logic        relay_on;
    logic        fault;
    logic [15:0] act_count;

    int checks = 0;
    int errors = 0;

    relay_coil_driver #(
        .CLK_FREQ  (1000),
        .PULLIN_MS (4),
        .HOLD_DUTY (4),
        .MIN_OFF_MS(8),
        .MAX_ON_SEC(1)
    ) dut (
        .clk        (clk),
        .reset      (rst_n),
        .relay_req_n(req_n),
        .fault_clr  (fault_clr),
        .coil_drv   (coil_drv),
        .relay_on   (relay_on),
        .fault      (fault),
        .act_count  (act_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        req_n;
        logic        clr;
        logic        e_coil;
        logic        e_on;
        logic        e_fault;
        logic [15:0] e_cnt;
    } vec_t;

    localparam int NVEC = 54;
    vec_t vecs [NVEC];

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic chk_all(input string name, input logic e_coil, input logic e_on,
                           input logic e_fault, input logic [15:0] e_cnt);
        chk({name, ".coil_drv"}, {15'd0, coil_drv}, {15'd0, e_coil});
        chk({name, ".relay_on"}, {15'd0, relay_on}, {15'd0, e_on});
        chk({name, ".fault"}, {15'd0, fault}, {15'd0, e_fault});
        chk({name, ".act_count"}, act_count, e_cnt);
    endtask

    // Drive inputs just after an edge, then sample 1 time unit after the next edge.
    task automatic step(input logic r, input logic c);
        req_n     = r;
        fault_clr = c;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Single activation (vectors 0..41) followed by a re-request inside lockout.
        for (int i = 0; i < NVEC; i++) begin
            vecs[i].clr     = 1'b0;
            vecs[i].e_fault = 1'b0;
            if (i == 0) begin
                vecs[i].req_n = 1'b1; vecs[i].e_coil = 1'b0; vecs[i].e_on = 1'b0; vecs[i].e_cnt = 16'd0;
            end else if (i <= 40) begin
                vecs[i].req_n  = 1'b0;
                vecs[i].e_on   = 1'b1;
                vecs[i].e_cnt  = 16'd1;
                vecs[i].e_coil = (i <= 4) ? 1'b1 : (((i - 5) % 16) < 4);
            end else if (i <= 42) begin
                vecs[i].req_n = 1'b1; vecs[i].e_coil = 1'b0; vecs[i].e_on = 1'b0; vecs[i].e_cnt = 16'd1;
            end else if (i <= 49) begin
                vecs[i].req_n = 1'b0; vecs[i].e_coil = 1'b0; vecs[i].e_on = 1'b0; vecs[i].e_cnt = 16'd1;
            end else begin
                vecs[i].req_n = 1'b0; vecs[i].e_coil = 1'b1; vecs[i].e_on = 1'b1; vecs[i].e_cnt = 16'd2;
            end
        end

        rst_n     = 1'b0;
        req_n     = 1'b1;
        fault_clr = 1'b0;
        #3;
        chk_all("reset", 1'b0, 1'b0, 1'b0, 16'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < NVEC; i++) begin
            step(vecs[i].req_n, vecs[i].clr);
            chk_all($sformatf("vec%0d", i), vecs[i].e_coil, vecs[i].e_on,
                    vecs[i].e_fault, vecs[i].e_cnt);
        end

        // Over-time fault: activation began at vector 50; fault on its 1000th edge.
        repeat (996) step(1'b0, 1'b0);
        chk_all("pre_fault", relay_on ? coil_drv : 1'b1, 1'b1, 1'b0, 16'd2);
        step(1'b0, 1'b0);
        chk_all("fault_trip", 1'b0, 1'b0, 1'b1, 16'd2);
        repeat (49) step(1'b0, 1'b0);
        chk_all("fault_held", 1'b0, 1'b0, 1'b1, 16'd2);
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        chk_all("clr_while_req", 1'b0, 1'b0, 1'b1, 16'd2);
        step(1'b1, 1'b0);
        chk_all("released_no_clr", 1'b0, 1'b0, 1'b1, 16'd2);
        step(1'b1, 1'b1);
        chk_all("fault_cleared", 1'b0, 1'b0, 1'b0, 16'd2);
        for (int k = 1; k <= 8; k++) begin
            step(1'b0, 1'b0);
            chk($sformatf("clr_lockout%0d.coil_drv", k), {15'd0, coil_drv}, 16'd0);
        end
        step(1'b0, 1'b0);
        chk_all("post_clr_pullin", 1'b1, 1'b1, 1'b0, 16'd3);

        // Release lands on the same edge as the timeout would.
        repeat (999) step(1'b0, 1'b0);
        chk_all("at_999", relay_on ? coil_drv : 1'b1, 1'b1, 1'b0, 16'd3);
        step(1'b1, 1'b0);
        chk_all("release_vs_timeout", 1'b0, 1'b0, 1'b0, 16'd3);
        repeat (8) step(1'b1, 1'b0);
        chk("no_late_fault", {15'd0, fault}, 16'd0);

        // Asynchronous reset in HOLD.
        step(1'b0, 1'b0);
        chk_all("act4_pullin", 1'b1, 1'b1, 1'b0, 16'd4);
        repeat (10) step(1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("async_reset", 1'b0, 1'b0, 1'b0, 16'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk_all("after_reset_pullin", 1'b1, 1'b1, 1'b0, 16'd1);

        // Saturation: preload near the top, then activate repeatedly.
        repeat (9) step(1'b1, 1'b0);
        force dut.act_count_q = 16'hFFFD;
        #1;
        release dut.act_count_q;
        for (int n = 0; n < 4; n++) begin
            step(1'b0, 1'b0);
            chk($sformatf("sat%0d", n), act_count, (n == 0) ? 16'hFFFE : 16'hFFFF);
            repeat (9) step(1'b1, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
